// File: rtl/alien_display_pkg.sv
// Shared types for the Alien calculator display stage: digit codes, active-low
// segment patterns, the code-to-segment decoder and the converter FSM states.
package alien_display_pkg;

  typedef logic [3:0] digit_code_t;

  localparam digit_code_t CODE_MINUS = 4'hA;
  localparam digit_code_t CODE_E     = 4'hB;
  localparam digit_code_t CODE_R     = 4'hC;
  localparam digit_code_t CODE_BLANK = 4'hF;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Segment order {dp,g,f,e,d,c,b,a}; a 0 lights the segment, dp stays dark.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_CONVERT
  } state_t;

  function automatic logic [7:0] seg_decode(input digit_code_t code);
    case (code)
      4'd0:       return SEG_0;
      4'd1:       return SEG_1;
      4'd2:       return SEG_2;
      4'd3:       return SEG_3;
      4'd4:       return SEG_4;
      4'd5:       return SEG_5;
      4'd6:       return SEG_6;
      4'd7:       return SEG_7;
      4'd8:       return SEG_8;
      4'd9:       return SEG_9;
      CODE_MINUS: return SEG_MINUS;
      CODE_E:     return SEG_E;
      CODE_R:     return SEG_R;
      default:    return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/alien_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: start loads the operand, MAG_W shift-add-3 steps follow.
// done is high during the last step and bcd then carries that step's result.
module bin2bcd_seq
  import alien_display_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(MAG_W + 1);

  logic [BCD_W-1:0]       bcd_q;
  logic [MAG_W-1:0]       bin_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   run_q;
  logic [BCD_W+MAG_W-1:0] step_w;

  // NOTE: blocking assignments here because each add-3 feeds the shift below it in the same pass.
  always_comb begin
    step_w = {bcd_q, bin_q};
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (step_w[MAG_W + 4*i +: 4] >= 4'd5)
        step_w[MAG_W + 4*i +: 4] = step_w[MAG_W + 4*i +: 4] + 4'd3;
    end
    step_w = step_w << 1;
  end

  assign done = run_q && (cnt_q == CNT_W'(1));
  assign bcd  = step_w[BCD_W+MAG_W-1 -: BCD_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start && !run_q) begin
      bcd_q <= '0;
      bin_q <= bin;
      cnt_q <= CNT_W'(MAG_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= step_w;
      cnt_q          <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alien_display_driver.sv
// Alien calculator display stage: capture result, convert to BCD, scan 8-digit display.
// Optional `LZ_BLANK_EN blanks leading zeros and floats the minus sign left of the value.
module alien_display_driver
  import alien_display_pkg::*;
#(
  parameter int MAG_W        = 8,
  parameter int REFRESH_BITS = 17
) (
  input  logic             clk,
  input  logic             rst_display_n,
  input  logic             res_valid,
  input  logic             res_sign,
  input  logic [MAG_W-1:0] res_mag,
  input  logic             res_err,
  output logic             busy,
  output logic [7:0]       seg_out,
  output logic [7:0]       digit_en
);

`ifdef LZ_BLANK_EN
  localparam digit_code_t RESET_LEAD = CODE_BLANK;
`else
  localparam digit_code_t RESET_LEAD = 4'd0;
`endif

  state_t                  state_q;
  logic                    cap_sign_q, cap_err_q, cap_nz_q;
  logic                    conv_start, conv_done;
  logic [BCD_W-1:0]        conv_bcd;
  digit_code_t             bcd_u, bcd_t, bcd_h;
  logic                    neg_w;
  digit_code_t             disp_q   [4];
  digit_code_t             layout_w [4];
  logic [REFRESH_BITS-1:0] scan_q;
  logic [2:0]              scan_sel;
  digit_code_t             scan_code;

  assign conv_start = (state_q == ST_IDLE) && res_valid;

  bin2bcd_seq #(.MAG_W(MAG_W)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_display_n),
    .start (conv_start),
    .bin   (res_mag),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign bcd_u = conv_bcd[3:0];
  assign bcd_t = conv_bcd[7:4];
  assign bcd_h = conv_bcd[11:8];
  assign neg_w = cap_sign_q && cap_nz_q;

  // NOTE: every layout entry gets a default first, so no path leaves a latch behind.
  always_comb begin
    layout_w[0] = bcd_u;
    layout_w[1] = bcd_t;
    layout_w[2] = bcd_h;
    layout_w[3] = CODE_BLANK;
`ifdef LZ_BLANK_EN
    if (bcd_h == 4'd0) begin
      layout_w[2] = CODE_BLANK;
      if (bcd_t == 4'd0) begin
        layout_w[1] = neg_w ? CODE_MINUS : CODE_BLANK;
      end else if (neg_w) begin
        layout_w[2] = CODE_MINUS;
      end
    end else if (neg_w) begin
      layout_w[3] = CODE_MINUS;
    end
`else
    if (neg_w) layout_w[3] = CODE_MINUS;
`endif
    if (cap_err_q) begin
      layout_w[0] = CODE_R;
      layout_w[1] = CODE_R;
      layout_w[2] = CODE_E;
      layout_w[3] = CODE_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_display_n) begin
    if (!rst_display_n) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      cap_sign_q <= 1'b0;
      cap_err_q  <= 1'b0;
      cap_nz_q   <= 1'b0;
      // NOTE: the display array is four flop-based digits, not a RAM, so it takes the async reset.
      disp_q[0]  <= 4'd0;
      disp_q[1]  <= RESET_LEAD;
      disp_q[2]  <= RESET_LEAD;
      disp_q[3]  <= CODE_BLANK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (res_valid) begin
            cap_sign_q <= res_sign;
            cap_err_q  <= res_err;
            cap_nz_q   <= (res_mag != '0);
            busy       <= 1'b1;
            state_q    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (conv_done) begin
            disp_q  <= layout_w;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Segment and anode registers load from the same counter value, so they never disagree.
  assign scan_sel  = scan_q[REFRESH_BITS-1 -: 3];
  assign scan_code = scan_sel[2] ? CODE_BLANK : disp_q[scan_sel[1:0]];

  always_ff @(posedge clk or negedge rst_display_n) begin
    if (!rst_display_n) begin
      scan_q   <= '0;
      seg_out  <= 8'hFF;
      digit_en <= 8'hFF;
    end else begin
      scan_q   <= scan_q + 1'b1;
      seg_out  <= seg_decode(scan_code);
      digit_en <= ~(8'b1 << scan_sel);
    end
  end

endmodule

// File: tb/tb_alien_display_driver.sv
// Self-checking bench for alien_display_driver (REFRESH_BITS=4); honours `LZ_BLANK_EN.
module tb_alien_display_driver;

  localparam int MAG_W        = 8;
  localparam int REFRESH_BITS = 4;

  logic       clk = 1'b0;
  logic       rst_display_n = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_sign = 1'b0;
  logic [7:0] res_mag = 8'd0;
  logic       res_err = 1'b0;
  logic       busy;
  logic [7:0] seg_out;
  logic [7:0] digit_en;

  int checks = 0;
  int passed = 0;

  logic [7:0] seen [8];
  bit         cur_sign = 1'b0;
  int         cur_mag  = 0;
  bit         cur_err  = 1'b0;

  always #5 clk = ~clk;

  alien_display_driver #(.MAG_W(MAG_W), .REFRESH_BITS(REFRESH_BITS)) dut (
    .clk           (clk),
    .rst_display_n (rst_display_n),
    .res_valid     (res_valid),
    .res_sign      (res_sign),
    .res_mag       (res_mag),
    .res_err       (res_err),
    .busy          (busy),
    .seg_out       (seg_out),
    .digit_en      (digit_en)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'h00;
    endcase
  endfunction

  // Reference: what the person at the display should see at position pos (0 = rightmost).
  function automatic logic [7:0] model_seg(input bit sign, input int mag, input bit err, input int pos);
    int  ndig;
    int  scale;
    bit  neg;
    if (pos > 3) return 8'hFF;
    if (err) begin
      if (pos == 2) return 8'h86;
      if (pos < 2)  return 8'hAF;
      return 8'hFF;
    end
    neg = sign && (mag != 0);
`ifdef LZ_BLANK_EN
    ndig = (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
`else
    ndig = 3;
`endif
    scale = (pos == 0) ? 1 : (pos == 1) ? 10 : 100;
    if (pos < ndig) return glyph((mag / scale) % 10);
    if (pos == ndig && neg) return 8'hBF;
    return 8'hFF;
  endfunction

  function automatic int one_cold_idx(input logic [7:0] en);
    int zeros = 0;
    int idx = -1;
    for (int j = 0; j < 8; j++) begin
      if (en[j] === 1'b0) begin
        zeros++;
        idx = j;
      end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  // Watches one full scan (16 clocks) and compares every digit to the model.
  task automatic scan_display(input string name, input bit sign, input int mag, input bit err);
    bit         bad = 1'b0;
    int         idx;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    repeat (16) begin
      @(negedge clk);
      idx = one_cold_idx(digit_en);
      if (idx < 0) bad = 1'b1;
      else seen[idx] = seg_out;
    end
    checks++;
    if (bad) $display("FAIL %s one_cold: digit_en=%h not one-cold during scan", name, digit_en);
    else passed++;
    for (int p = 0; p < 8; p++) begin
      exp = model_seg(sign, mag, err, p);
      checks++;
      if (seen[p] !== exp)
        $display("FAIL %s d%0d: got %h expected %h (sign=%0d mag=%0d err=%0d)",
                 name, p, seen[p], exp, sign, mag, err);
      else passed++;
    end
  endtask

  task automatic send(input bit sign, input int mag, input bit err);
    @(negedge clk);
    res_valid = 1'b1;
    res_sign  = sign;
    res_mag   = 8'(mag);
    res_err   = err;
    @(negedge clk);
    res_valid = 1'b0;
    res_sign  = 1'($urandom);
    res_mag   = 8'($urandom);
    res_err   = 1'($urandom);
  endtask

  // Strobe one result, check busy length and that the old value holds, then check the new one.
  task automatic run_conversion(input string name, input bit sign, input int mag, input bit err);
    int n = 0;
    int idx;
    bit stale = 1'b0;
    send(sign, mag, err);
    while (busy === 1'b1 && n < 30) begin
      idx = one_cold_idx(digit_en);
      if (idx < 0 || seg_out !== model_seg(cur_sign, cur_mag, cur_err, idx)) stale = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != MAG_W) $display("FAIL %s busy_len: got %0d cycles expected %0d", name, n, MAG_W);
    else passed++;
    checks++;
    if (stale) $display("FAIL %s hold_old: display changed before commit (got seg %h)", name, seg_out);
    else passed++;
    cur_sign = sign;
    cur_mag  = mag;
    cur_err  = err;
    scan_display(name, sign, mag, err);
  endtask

  task automatic test_reset();
    rst_display_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seg_out !== 8'hFF || digit_en !== 8'hFF)
      $display("FAIL reset_hold: busy=%b seg=%h en=%h expected 0/FF/FF", busy, seg_out, digit_en);
    else passed++;
    rst_display_n = 1'b1;
    #1;
    checks++;
    if (seg_out !== 8'hFF || digit_en !== 8'hFF)
      $display("FAIL reset_release: seg=%h en=%h expected FF/FF", seg_out, digit_en);
    else passed++;
    @(negedge clk);
    checks++;
    if (seg_out !== 8'hC0 || digit_en !== 8'hFE)
      $display("FAIL reset_first_digit: seg=%h en=%h expected C0/FE", seg_out, digit_en);
    else passed++;
    cur_sign = 1'b0;
    cur_mag  = 0;
    cur_err  = 1'b0;
    scan_display("reset_zero", 1'b0, 0, 1'b0);
  endtask

  task automatic test_directed();
    run_conversion("pos_18", 1'b0, 18, 1'b0);
    run_conversion("neg_81", 1'b1, 81, 1'b0);
    run_conversion("err", 1'b0, 0, 1'b1);
    run_conversion("neg_zero", 1'b1, 0, 1'b0);
    run_conversion("neg_5", 1'b1, 5, 1'b0);
    run_conversion("neg_42", 1'b1, 42, 1'b0);
    run_conversion("neg_128", 1'b1, 128, 1'b0);
    run_conversion("pos_255", 1'b0, 255, 1'b0);
    run_conversion("pos_100", 1'b0, 100, 1'b0);
    run_conversion("err_neg", 1'b1, 77, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++)
      run_conversion("random", 1'($urandom), int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
  endtask

  task automatic test_drop_while_busy();
    int n = 0;
    bit restarted = 1'b0;
    send(1'b0, 203, 1'b0);
    repeat (2) @(negedge clk);
    res_valid = 1'b1;
    res_sign  = 1'b0;
    res_mag   = 8'd7;
    res_err   = 1'b0;
    @(negedge clk);
    res_valid = 1'b0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    repeat (4) begin
      if (busy !== 1'b0) restarted = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (restarted || n >= 30)
      $display("FAIL drop_busy: busy activity after first conversion (n=%0d restarted=%0d) expected none", n, restarted);
    else passed++;
    cur_sign = 1'b0;
    cur_mag  = 203;
    cur_err  = 1'b0;
    scan_display("drop_keep_first", 1'b0, 203, 1'b0);
  endtask

  task automatic test_scan();
    logic [7:0] prev;
    logic [7:0] exp;
    bit found = 1'b0;
    int bad = 0;
    @(negedge clk);
    prev = digit_en;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (prev === 8'h7F && digit_en === 8'hFE) found = 1'b1;
      else prev = digit_en;
    end
    checks++;
    if (!found) $display("FAIL scan_wrap: never saw 7F -> FE, last digit_en=%h expected FE", digit_en);
    else passed++;
    for (int i = 1; i < 34; i++) begin
      @(negedge clk);
      exp = ~(8'b1 << ((i / 2) % 8));
      checks++;
      if (digit_en !== exp) begin
        bad++;
        if (bad < 4) $display("FAIL scan_step%0d: digit_en=%h expected %h", i, digit_en, exp);
      end else passed++;
    end
  endtask

  task automatic test_reset_mid_conversion();
    send(1'b1, 199, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_display_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || seg_out !== 8'hFF || digit_en !== 8'hFF)
      $display("FAIL reset_mid: busy=%b seg=%h en=%h expected 0/FF/FF", busy, seg_out, digit_en);
    else passed++;
    @(negedge clk);
    rst_display_n = 1'b1;
    cur_sign = 1'b0;
    cur_mag  = 0;
    cur_err  = 1'b0;
    scan_display("reset_mid_zero", 1'b0, 0, 1'b0);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy: busy=%b expected 0", busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_drop_while_busy();
    test_scan();
    test_reset_mid_conversion();
    run_conversion("after_reset", 1'b1, 64, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
